round_fsm: RTL

Parametrised match/round controller for the fighting-game top level, successor to the single-round game-state machine. Sequences title screen, per-round 3-2-1-FIGHT countdown, live play with a seconds timer and pause, KO/time-up handling, and best-of-N match scoring. It feeds the sprite/text renderers (state code, countdown enable, timer, scores) and gates player input via `play_en`. All state changes are paced by the 60 Hz `frame_clk`.

---
 rtl/round_fsm.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/round_fsm.sv
// round_fsm: match/round controller. Sequences title, countdown, live play
// with a seconds timer and pause, KO/time-up banners and best-of-N scoring.
// Every state change is paced by a tick derived from the frame clock.
module round_fsm #(
  parameter int FPS           = 60,
  parameter int COUNT_FRAMES  = 90,
  parameter int KO_FRAMES     = 140,
  parameter int ROUND_TIME    = 99,
  parameter int ROUNDS_TO_WIN = 2,
  parameter int MAX_ROUNDS    = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic       ko_p1,
  input  logic       ko_p2,
  output logic [3:0] state,
  output logic       title_screen,
  output logic       countdown_en,
  output logic       play_en,
  output logic       round_start,
  output logic [2:0] round_num,
  output logic [2:0] wins_p1,
  output logic [2:0] wins_p2,
  output logic [6:0] timer_sec,
  output logic [1:0] winner
);

  typedef enum logic [3:0] {
    S_TITLE     = 4'd0,
    S_SETUP     = 4'd1,
    S_COUNT3    = 4'd2,
    S_COUNT2    = 4'd3,
    S_COUNT1    = 4'd4,
    S_FIGHT     = 4'd5,
    S_PLAY      = 4'd6,
    S_PAUSE     = 4'd7,
    S_KO        = 4'd8,
    S_TIMEUP    = 4'd9,
    S_MATCH_END = 4'd10
  } state_t;

  localparam logic [7:0] COUNT_LAST = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] FPS_LAST   = 8'(FPS - 1);
  localparam logic [7:0] KO_LAST    = 8'(KO_FRAMES - 1);
  localparam logic [6:0] TIME_INIT  = 7'(ROUND_TIME);
  localparam logic [2:0] WIN_TARGET = 3'(ROUNDS_TO_WIN);
  localparam logic [2:0] ROUND_CAP  = 3'(MAX_ROUNDS);

  state_t     state_reg, state_next;
  logic       frame_d_reg, tick_reg;
  logic [1:0] key_now, key_prev_reg, key_rise;
  logic [7:0] frame_cnt_reg, frame_cnt_next;
  logic [2:0] round_reg, round_next;
  logic [2:0] wins1_reg, wins1_next;
  logic [2:0] wins2_reg, wins2_next;
  logic [6:0] timer_reg, timer_next;
  logic [1:0] winner_reg, winner_next;
  logic       title_reg, countdown_reg, play_reg, round_start_reg;

  // Key edges are tick-to-tick: bit 0 is start, bit 1 is pause.
  assign key_now = {pause_key, start_key};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key_edge
      assign key_rise[gi] = key_now[gi] & ~key_prev_reg[gi];
    end
  endgenerate

  // Next-state and counter logic; nothing moves unless this is a tick cycle.
  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    round_next     = round_reg;
    wins1_next     = wins1_reg;
    wins2_next     = wins2_reg;
    timer_next     = timer_reg;
    winner_next    = winner_reg;
    if (tick_reg) begin
      case (state_reg)
        S_TITLE: begin
          if (start_key) begin
            state_next = S_SETUP;
            wins1_next = '0;
            wins2_next = '0;
            round_next = 3'd1;
          end
        end
        S_SETUP: begin
          timer_next = TIME_INIT;
          state_next = S_COUNT3;
        end
        S_COUNT3, S_COUNT2, S_COUNT1, S_FIGHT: begin
          // FIGHT + 1 is PLAY, so the four phases chain by increment.
          if (frame_cnt_reg == COUNT_LAST) state_next = state_t'(state_reg + 4'd1);
          else frame_cnt_next = frame_cnt_reg + 8'd1;
        end
        S_PLAY: begin
          if (ko_p1 || ko_p2) begin
            if (ko_p1 && !ko_p2 && wins2_reg != 3'd7) wins2_next = wins2_reg + 3'd1;
            if (ko_p2 && !ko_p1 && wins1_reg != 3'd7) wins1_next = wins1_reg + 3'd1;
            state_next = S_KO;
          end else if (timer_reg == 7'd0) begin
            state_next = S_TIMEUP;
          end else if (key_rise[1]) begin
            state_next = S_PAUSE;
          end else if (frame_cnt_reg == FPS_LAST) begin
            frame_cnt_next = '0;
            timer_next     = timer_reg - 7'd1;
          end else begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end
        end
        S_PAUSE: begin
          if (key_rise[1]) state_next = S_PLAY;
        end
        S_KO, S_TIMEUP: begin
          if (frame_cnt_reg == KO_LAST) begin
            if (wins1_reg >= WIN_TARGET || wins2_reg >= WIN_TARGET || round_reg >= ROUND_CAP) begin
              state_next = S_MATCH_END;
              if (wins1_reg > wins2_reg)      winner_next = 2'b01;
              else if (wins2_reg > wins1_reg) winner_next = 2'b10;
              else                            winner_next = 2'b11;
            end else begin
              round_next = round_reg + 3'd1;
              state_next = S_SETUP;
            end
          end else begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end
        end
        S_MATCH_END: begin
          if (key_rise[0]) begin
            state_next  = S_TITLE;
            winner_next = 2'b00;
          end
        end
        default: begin
          state_next  = S_TITLE;
          winner_next = 2'b00;
        end
      endcase
    end
    if (state_next != state_reg) frame_cnt_next = '0;
  end

  // State, counters, tick detection and registered decode of the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= S_TITLE;
      frame_d_reg     <= 1'b0;
      tick_reg        <= 1'b0;
      key_prev_reg    <= '0;
      frame_cnt_reg   <= '0;
      round_reg       <= 3'd1;
      wins1_reg       <= '0;
      wins2_reg       <= '0;
      timer_reg       <= '0;
      winner_reg      <= '0;
      title_reg       <= 1'b1;
      countdown_reg   <= 1'b0;
      play_reg        <= 1'b0;
      round_start_reg <= 1'b0;
    end else begin
      frame_d_reg     <= frame_clk;
      tick_reg        <= frame_clk & ~frame_d_reg;
      if (tick_reg) key_prev_reg <= key_now;
      state_reg       <= state_next;
      frame_cnt_reg   <= frame_cnt_next;
      round_reg       <= round_next;
      wins1_reg       <= wins1_next;
      wins2_reg       <= wins2_next;
      timer_reg       <= timer_next;
      winner_reg      <= winner_next;
      title_reg       <= (state_next == S_TITLE);
      countdown_reg   <= (state_next inside {S_COUNT3, S_COUNT2, S_COUNT1, S_FIGHT, S_KO, S_TIMEUP});
      play_reg        <= (state_next == S_PLAY);
      round_start_reg <= tick_reg && (state_reg == S_SETUP);
    end
  end

  assign state        = state_reg;
  assign title_screen = title_reg;
  assign countdown_en = countdown_reg;
  assign play_en      = play_reg;
  assign round_start  = round_start_reg;
  assign round_num    = round_reg;
  assign wins_p1      = wins1_reg;
  assign wins_p2      = wins2_reg;
  assign timer_sec    = timer_reg;
  assign winner       = winner_reg;

endmodule
